// File: rtl/board_io_pkg.sv
// Shared register addresses, the bus word type and the saturating counter helper
// used by the board input capture block.
package board_io_pkg;

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_BTN  = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_SNAP = 2'd3;

    typedef logic [31:0] io_word_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One board input: 2-FF synchroniser followed by a hold-time debouncer that accepts
// a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Any return to the accepted level restarts the hold count from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/board_input_capture.sv
// Switch/button capture for the processor data space: debounce, press detect, sticky
// pending bits, switch snapshot and a 1-cycle read port. Optional INPUT_PRESS_COUNT_EN.
module board_input_capture
    import board_io_pkg::*;
#(
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               rd_en,
    input  logic [1:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               irq
);

    logic [NUM_SW-1:0]  w_sw_lvl;
    logic [NUM_BTN-1:0] w_btn_lvl;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] r_btn_prev;
    logic [NUM_BTN-1:0] r_pend;
    logic [NUM_SW-1:0]  r_snap;
    logic [15:0]        w_snap_hi;
    logic               w_pend_clr;
    io_word_t           w_rd_mux;
    io_word_t           r_rd_data;
    logic               r_irq;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst(rst), .raw(sw_in[g]), .level(w_sw_lvl[g])
        );
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst(rst), .raw(btn_in[g]), .level(w_btn_lvl[g])
        );
    end

    assign w_press    = w_btn_lvl & ~r_btn_prev;
    assign w_pend_clr = rd_en && (rd_addr == ADDR_PEND);

    // A press landing on the clearing edge is OR-ed in after the clear, so it survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_prev <= '0;
            r_pend     <= '0;
            r_snap     <= '0;
            r_rd_data  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_lvl;
            r_pend     <= (w_pend_clr ? '0 : r_pend) | w_press;
            r_irq      <= |r_pend;
            if (w_press[0]) r_snap <= w_sw_lvl;
            if (rd_en) r_rd_data <= w_rd_mux;
        end
    end

`ifdef INPUT_PRESS_COUNT_EN
    localparam int CNT_N = (NUM_BTN < 2) ? 2 : NUM_BTN;

    logic [CNT_N-1:0] w_press_ext;
    logic [7:0]       r_cnt [CNT_N];
    logic             w_snap_rd;

    assign w_press_ext = CNT_N'(w_press);
    assign w_snap_rd   = rd_en && (rd_addr == ADDR_SNAP);

    // Only the two counters visible in SNAP are cleared by reading it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CNT_N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CNT_N; i++) begin
                if (w_snap_rd && (i < 2)) r_cnt[i] <= {7'd0, w_press_ext[i]};
                else if (w_press_ext[i])  r_cnt[i] <= sat_inc8(r_cnt[i]);
            end
        end
    end

    assign w_snap_hi = {r_cnt[1], r_cnt[0]};
`else
    assign w_snap_hi = 16'h0000;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_SW:   w_rd_mux[NUM_SW-1:0]  = w_sw_lvl;
            ADDR_BTN:  w_rd_mux[NUM_BTN-1:0] = w_btn_lvl;
            ADDR_PEND: w_rd_mux[NUM_BTN-1:0] = r_pend;
            default: begin
                w_rd_mux[NUM_SW-1:0] = r_snap;
                w_rd_mux[31:16]      = w_snap_hi;
            end
        endcase
    end

    assign rd_data = r_rd_data;
    assign irq     = r_irq;

endmodule
